// File: rtl/dcf77_encoder.sv
// DCF77 time-code transmitter: shadowed BCD time fields, 59-bit frame,
// 100/200 ms second pulses, silent second 59 as the minute mark.
`timescale 1ns/1ps
module dcf77_encoder #(
  parameter int unsigned TICKS_PER_100MS = 1000000
) (
  input  logic       clk_in,
  input  logic       rst_n_in,
  input  logic       enable_in,
  input  logic       time_load_in,
  input  logic       dst_in,
  input  logic [6:0] minute_bcd_in,
  input  logic [5:0] hour_bcd_in,
  input  logic [5:0] day_bcd_in,
  input  logic [2:0] weekday_in,
  input  logic [4:0] month_bcd_in,
  input  logic [7:0] year_bcd_in,
  output logic       dcf_out,
  output logic [5:0] second_out,
  output logic       sec_tick_out,
  output logic       frame_req_out,
  output logic       stale_out,
  output logic       running_out
);

  localparam int unsigned TW =
    (TICKS_PER_100MS > 1) ? $clog2(TICKS_PER_100MS) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(TICKS_PER_100MS - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t        state_q, state_d;
  logic [TW-1:0] tick_q, tick_d;
  logic [3:0]    tenth_q, tenth_d;
  logic [5:0]    sec_q, sec_d;
  logic [58:0]   frame_q, frame_d, frame_new;
  logic [59:0]   frame_ext;
  logic          stale_q, stale_d;
  logic          fresh_q, fresh_d;
  logic          valid_q;
  logic          dcf_q, dcf_d;
  logic          stick_q, stick_d;
  logic          req_q, req_d;

  logic [6:0] sh_min;
  logic [5:0] sh_hour;
  logic [5:0] sh_day;
  logic [2:0] sh_wday;
  logic [4:0] sh_month;
  logic [7:0] sh_year;
  logic       sh_dst;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      sh_min   <= '0;
      sh_hour  <= '0;
      sh_day   <= '0;
      sh_wday  <= '0;
      sh_month <= '0;
      sh_year  <= '0;
      sh_dst   <= 1'b0;
      valid_q  <= 1'b0;
    end else if (time_load_in) begin
      sh_min   <= minute_bcd_in;
      sh_hour  <= hour_bcd_in;
      sh_day   <= day_bcd_in;
      sh_wday  <= weekday_in;
      sh_month <= month_bcd_in;
      sh_year  <= year_bcd_in;
      sh_dst   <= dst_in;
      valid_q  <= 1'b1;
    end
  end

  always_comb begin
    frame_new        = '0;
    frame_new[17]    = sh_dst;
    frame_new[18]    = ~sh_dst;
    frame_new[20]    = 1'b1;
    frame_new[27:21] = sh_min;
    frame_new[28]    = ^sh_min;
    frame_new[34:29] = sh_hour;
    frame_new[35]    = ^sh_hour;
    frame_new[41:36] = sh_day;
    frame_new[44:42] = sh_wday;
    frame_new[49:45] = sh_month;
    frame_new[57:50] = sh_year;
    frame_new[58]    = ^{sh_year, sh_month, sh_wday, sh_day};
  end

  always_comb begin
    state_d   = state_q;
    tick_d    = tick_q;
    tenth_d   = tenth_q;
    sec_d     = sec_q;
    frame_d   = frame_q;
    stale_d   = stale_q;
    fresh_d   = fresh_q;
    stick_d   = 1'b0;
    req_d     = 1'b0;
    dcf_d     = 1'b0;
    frame_ext = '0;
    unique case (state_q)
      IDLE: begin
        if (enable_in && valid_q) begin
          state_d = RUN;
          tick_d  = '0;
          tenth_d = '0;
          sec_d   = '0;
          frame_d = frame_new;
          stale_d = ~fresh_q;
          fresh_d = 1'b0;
          stick_d = 1'b1;
        end
      end
      RUN: begin
        if (!enable_in) begin
          state_d = IDLE;
          tick_d  = '0;
          tenth_d = '0;
          sec_d   = '0;
        end else if (tick_q != TICK_LAST) begin
          tick_d = tick_q + 1'b1;
        end else begin
          tick_d = '0;
          if (tenth_q != 4'd9) begin
            tenth_d = tenth_q + 4'd1;
          end else begin
            tenth_d = '0;
            stick_d = 1'b1;
            if (sec_q != 6'd59) begin
              sec_d = sec_q + 6'd1;
            end else begin
              // minute wrap: next frame comes from the shadow as it stands
              sec_d   = '0;
              frame_d = frame_new;
              stale_d = ~fresh_q;
              fresh_d = 1'b0;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
    if (time_load_in) fresh_d = 1'b1;
    req_d     = stick_d && (sec_d == 6'd50);
    frame_ext = {1'b0, frame_d};
    if (state_d == RUN)
      dcf_d = (sec_d != 6'd59) &&
              ((tenth_d == 4'd0) ||
               ((tenth_d == 4'd1) && frame_ext[sec_d]));
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q <= IDLE;
      tick_q  <= '0;
      tenth_q <= '0;
      sec_q   <= '0;
      frame_q <= '0;
      stale_q <= 1'b0;
      fresh_q <= 1'b0;
      dcf_q   <= 1'b0;
      stick_q <= 1'b0;
      req_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      tick_q  <= tick_d;
      tenth_q <= tenth_d;
      sec_q   <= sec_d;
      frame_q <= frame_d;
      stale_q <= stale_d;
      fresh_q <= fresh_d;
      dcf_q   <= dcf_d;
      stick_q <= stick_d;
      req_q   <= req_d;
    end
  end

  assign dcf_out       = dcf_q;
  assign second_out    = sec_q;
  assign sec_tick_out  = stick_q;
  assign frame_req_out = req_q;
  assign stale_out     = stale_q;
  assign running_out   = (state_q == RUN);

endmodule

// File: tb/tb_dcf77_encoder.sv
// Bench for dcf77_encoder: cycle model from elapsed-time arithmetic,
// table and random frames decoded back from measured pulse widths.
`timescale 1ns/1ps
module tb_dcf77_encoder;

  localparam int T   = 4;
  localparam int SPS = 10 * T;
  localparam int FR  = 60 * SPS;
  localparam int NV  = 4;

  typedef struct {
    logic [6:0] mn;
    logic [5:0] hr;
    logic [5:0] dy;
    logic [2:0] wd;
    logic [4:0] mo;
    logic [7:0] yr;
    logic       dst;
  } tf_t;

  typedef struct {
    tf_t f;
    bit  p1;
    bit  p2;
    bit  p3;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic en = 1'b0;
  logic ld = 1'b0;
  tf_t  cur;

  logic       dcf_out;
  logic [5:0] second_out;
  logic       sec_tick_out;
  logic       frame_req_out;
  logic       stale_out;
  logic       running_out;

  always #5 clk = ~clk;

  dcf77_encoder #(.TICKS_PER_100MS(T)) dut (
    .clk_in        (clk),
    .rst_n_in      (rst_n),
    .enable_in     (en),
    .time_load_in  (ld),
    .dst_in        (cur.dst),
    .minute_bcd_in (cur.mn),
    .hour_bcd_in   (cur.hr),
    .day_bcd_in    (cur.dy),
    .weekday_in    (cur.wd),
    .month_bcd_in  (cur.mo),
    .year_bcd_in   (cur.yr),
    .dcf_out       (dcf_out),
    .second_out    (second_out),
    .sec_tick_out  (sec_tick_out),
    .frame_req_out (frame_req_out),
    .stale_out     (stale_out),
    .running_out   (running_out)
  );

  bit        m_run, m_valid, m_fresh, m_stale;
  int        m_k;
  bit [58:0] m_frame;
  tf_t       m_sh;
  int        hi [60];
  int        hi1 [60];
  int        n_chk = 0;
  int        n_err = 0;
  vec_t      vec [NV];

  task automatic chk(string nm, int act, int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int ones(bit [58:0] b, int lo, int hh);
    int n = 0;
    for (int i = lo; i <= hh; i++) n += b[i];
    return n;
  endfunction

  function automatic bit [58:0] mframe(tf_t f);
    bit [58:0] b = '0;
    b[17] = f.dst;
    b[18] = !f.dst;
    b[20] = 1'b1;
    for (int i = 0; i < 7; i++) b[21+i] = f.mn[i];
    b[28] = (ones(b, 21, 27) % 2) == 1;
    for (int i = 0; i < 6; i++) b[29+i] = f.hr[i];
    b[35] = (ones(b, 29, 34) % 2) == 1;
    for (int i = 0; i < 6; i++) b[36+i] = f.dy[i];
    for (int i = 0; i < 3; i++) b[42+i] = f.wd[i];
    for (int i = 0; i < 5; i++) b[45+i] = f.mo[i];
    for (int i = 0; i < 8; i++) b[50+i] = f.yr[i];
    b[58] = (ones(b, 36, 57) % 2) == 1;
    return b;
  endfunction

  function automatic int to_bcd(int v);
    return ((v / 10) << 4) | (v % 10);
  endfunction

  function automatic tf_t rnd_fields();
    tf_t f;
    f.mn  = 7'(to_bcd(int'($urandom_range(0, 59))));
    f.hr  = 6'(to_bcd(int'($urandom_range(0, 23))));
    f.dy  = 6'(to_bcd(int'($urandom_range(1, 31))));
    f.wd  = 3'($urandom_range(1, 7));
    f.mo  = 5'(to_bcd(int'($urandom_range(1, 12))));
    f.yr  = 8'(to_bcd(int'($urandom_range(0, 99))));
    f.dst = 1'($urandom_range(0, 1));
    return f;
  endfunction

  function automatic vec_t mkv(int mn, int hr, int dy, int wd, int mo,
                               int yr, int dst, int p1, int p2, int p3);
    vec_t v;
    v.f.mn  = 7'(mn);
    v.f.hr  = 6'(hr);
    v.f.dy  = 6'(dy);
    v.f.wd  = 3'(wd);
    v.f.mo  = 5'(mo);
    v.f.yr  = 8'(yr);
    v.f.dst = 1'(dst);
    v.p1    = 1'(p1);
    v.p2    = 1'(p2);
    v.p3    = 1'(p3);
    return v;
  endfunction

  function automatic int field(int lo, int n);
    int v = 0;
    for (int i = 0; i < n; i++)
      if (hi[lo+i] == 2 * T) v |= (1 << i);
    return v;
  endfunction

  task automatic tick();
    int ph, s, t;
    bit ed, et, eq;
    @(posedge clk);
    if (!m_run) begin
      if (en && m_valid) begin
        m_run   = 1;
        m_k     = 0;
        m_frame = mframe(m_sh);
        m_stale = !m_fresh;
        m_fresh = 0;
      end
    end else if (!en) begin
      m_run = 0;
      m_k   = 0;
    end else begin
      m_k++;
      if (m_k % FR == 0) begin
        m_frame = mframe(m_sh);
        m_stale = !m_fresh;
        m_fresh = 0;
      end
    end
    if (ld) begin
      m_sh    = cur;
      m_valid = 1;
      m_fresh = 1;
    end
    #1;
    ph = m_k % FR;
    s  = ph / SPS;
    t  = (ph % SPS) / T;
    ed = m_run && (s != 59) && ((t == 0) || ((t == 1) && m_frame[s]));
    et = m_run && (ph % SPS == 0);
    eq = et && (s == 50);
    chk("dcf_out", int'(dcf_out), int'(ed));
    chk("second_out", int'(second_out), m_run ? s : 0);
    chk("sec_tick_out", int'(sec_tick_out), int'(et));
    chk("frame_req_out", int'(frame_req_out), int'(eq));
    chk("stale_out", int'(stale_out), int'(m_stale));
    chk("running_out", int'(running_out), int'(m_run));
    if (m_run && dcf_out === 1'b1) hi[s]++;
  endtask

  task automatic run_until(int tgt);
    int n = 0;
    do begin
      tick();
      n++;
    end while (!(m_run && (m_k % FR == tgt)) && n < 3 * FR);
    chk("run_until_reached", m_run ? (m_k % FR) : -1, tgt);
  endtask

  task automatic load(tf_t f);
    cur = f;
    ld  = 1'b1;
    tick();
    ld  = 1'b0;
  endtask

  task automatic clear_hi();
    for (int i = 0; i < 60; i++) hi[i] = 0;
  endtask

  task automatic check_frame(string tag, tf_t f, bit p1, bit p2, bit p3);
    int bad = 0;
    for (int s = 0; s < 59; s++)
      if (hi[s] != T && hi[s] != 2 * T) bad++;
    chk({tag, "_widths"}, bad, 0);
    chk({tag, "_sec0"}, hi[0], T);
    chk({tag, "_sec59"}, hi[59], 0);
    chk({tag, "_bit20"}, hi[20], 2 * T);
    chk({tag, "_z1"}, field(17, 1), int'(f.dst));
    chk({tag, "_z2"}, field(18, 1), int'(!f.dst));
    chk({tag, "_min"}, field(21, 7), int'(f.mn));
    chk({tag, "_p1"}, field(28, 1), int'(p1));
    chk({tag, "_hour"}, field(29, 6), int'(f.hr));
    chk({tag, "_p2"}, field(35, 1), int'(p2));
    chk({tag, "_day"}, field(36, 6), int'(f.dy));
    chk({tag, "_wday"}, field(42, 3), int'(f.wd));
    chk({tag, "_month"}, field(45, 5), int'(f.mo));
    chk({tag, "_year"}, field(50, 8), int'(f.yr));
    chk({tag, "_p3"}, field(58, 1), int'(p3));
  endtask

  initial begin
    tf_t       rf;
    bit [58:0] pb;
    int        diffs;

    vec[0] = mkv('h34, 'h12, 'h16, 4, 'h05, 'h24, 1, 1, 0, 0);
    vec[1] = mkv('h00, 'h23, 'h01, 1, 'h01, 'h00, 0, 0, 1, 1);
    vec[2] = mkv('h59, 'h23, 'h31, 7, 'h12, 'h99, 0, 0, 1, 0);
    vec[3] = mkv('h01, 'h01, 'h01, 1, 'h01, 'h01, 1, 1, 1, 0);
    cur = vec[3].f;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_dcf", int'(dcf_out), 0);
    chk("rst_second", int'(second_out), 0);
    chk("rst_tick", int'(sec_tick_out), 0);
    chk("rst_req", int'(frame_req_out), 0);
    chk("rst_stale", int'(stale_out), 0);
    chk("rst_running", int'(running_out), 0);
    rst_n = 1'b1;

    en = 1'b1;
    repeat (20) tick();
    chk("noload_idle", int'(running_out), 0);

    clear_hi();
    load(vec[0].f);
    run_until(FR - 1);
    check_frame("f1", vec[0].f, vec[0].p1, vec[0].p2, vec[0].p3);
    chk("f1_sec17", hi[17], 2 * T);
    chk("f1_sec28", hi[28], 2 * T);
    for (int i = 0; i < 60; i++) hi1[i] = hi[i];

    clear_hi();
    run_until(55 * SPS);
    chk("f2_stale", int'(stale_out), 1);
    load(vec[1].f);
    run_until(FR - 1);
    diffs = 0;
    for (int i = 0; i < 60; i++) if (hi[i] != hi1[i]) diffs++;
    chk("f2_repeat_diffs", diffs, 0);

    clear_hi();
    run_until(FR - 1);
    chk("f3_stale", int'(stale_out), 0);
    check_frame("f3", vec[1].f, vec[1].p1, vec[1].p2, vec[1].p3);

    clear_hi();
    load(vec[2].f);
    run_until(FR - 1);
    chk("f4_stale", int'(stale_out), 1);
    check_frame("f4_old", vec[1].f, vec[1].p1, vec[1].p2, vec[1].p3);

    clear_hi();
    run_until(FR - 1);
    chk("f5_stale", int'(stale_out), 0);
    check_frame("f5_new", vec[2].f, vec[2].p1, vec[2].p2, vec[2].p3);

    for (int r = 0; r < NV; r++) begin
      run_until(40 * SPS);
      load(vec[r].f);
      run_until(FR - 1);
      clear_hi();
      run_until(FR - 1);
      check_frame($sformatf("tbl%0d", r), vec[r].f,
                  vec[r].p1, vec[r].p2, vec[r].p3);
    end

    for (int r = 0; r < 3; r++) begin
      rf = rnd_fields();
      pb = mframe(rf);
      run_until(int'($urandom_range(1, 58)) * SPS +
                int'($urandom_range(0, SPS - 1)));
      load(rf);
      run_until(FR - 1);
      clear_hi();
      run_until(FR - 1);
      check_frame($sformatf("rnd%0d", r), rf, pb[28], pb[35], pb[58]);
    end

    run_until(30 * SPS + T);
    en = 1'b0;
    tick();
    chk("drop_dcf", int'(dcf_out), 0);
    chk("drop_second", int'(second_out), 0);
    chk("drop_running", int'(running_out), 0);
    repeat (5) tick();
    en = 1'b1;
    tick();
    chk("restart_second", int'(second_out), 0);
    chk("restart_dcf", int'(dcf_out), 1);
    chk("restart_tick", int'(sec_tick_out), 1);

    run_until(SPS + 2);
    chk("pre_rst_dcf", int'(dcf_out), 1);
    #2;
    rst_n   = 1'b0;
    m_run   = 0;
    m_k     = 0;
    m_valid = 0;
    m_fresh = 0;
    m_stale = 0;
    #1;
    chk("async_rst_dcf", int'(dcf_out), 0);
    chk("async_rst_running", int'(running_out), 0);
    chk("async_rst_second", int'(second_out), 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (20) tick();
    chk("post_rst_idle", int'(running_out), 0);
    load(vec[0].f);
    repeat (100) tick();
    chk("post_load_running", int'(running_out), 1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_err);
    $finish;
  end

endmodule
